// File: rtl/pip_pkg.sv
// Shared constants and the delay-line stage record for the TSMP frame filter.
package pip_pkg;

  localparam logic [15:0] TSMP_ETYPE   = 16'hFF01;
  localparam int          ETYPE_HI_IDX = 12;
  localparam int          ETYPE_LO_IDX = 13;
  localparam int          PIP_LATENCY  = 14;
  localparam int          CNT_W        = 5;

  typedef struct packed {
    logic       par;
    logic       valid;
    logic [8:0] data;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

endpackage

// File: rtl/pip_delay_line.sv
// Fixed-depth shift register that advances on every clock; cleared by reset.
module pip_delay_line #(
  parameter int DEPTH = 14,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      regs[0] <= d;
      for (int i = 1; i < DEPTH; i++) regs[i] <= regs[i-1];
    end
  end

  assign q = regs[DEPTH-1];

endmodule

// File: rtl/pip.sv
// TSMP frame filter: forwards frames whose EtherType is 0xFF01 with a fixed
// latency, drops all other frames, short frames and truncated frames.
module pip
  import pip_pkg::*;
#(
  parameter int DATA_WIDTH = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] iv_data,
  input  logic                  i_data_wr,
  output logic [DATA_WIDTH-1:0] ov_data,
  output logic                  o_data_wr
);

  logic             in_frame;
  logic             parity;
  logic [1:0]       keep;
  logic             hi_match;
  logic [CNT_W-1:0] byte_cnt;

  logic   is_start, is_end, is_body, truncated, accept, cur_par, fwd_ok;
  stage_t s_in, s_out;

  // A boundary byte opens a frame when idle and closes it when inside one.
  always_comb begin
    is_start  = i_data_wr && iv_data[8] && !in_frame;
    is_end    = i_data_wr && iv_data[8] && in_frame;
    is_body   = i_data_wr && !iv_data[8] && in_frame;
    truncated = !i_data_wr && in_frame;
    accept    = is_start || is_end || is_body;
    cur_par   = is_start ? ~parity : parity;
    s_in.par   = cur_par;
    s_in.valid = accept;
    s_in.data  = accept ? iv_data : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      in_frame <= 1'b0;
      parity   <= 1'b0;
      keep     <= 2'b00;
      hi_match <= 1'b0;
      byte_cnt <= '0;
    end else if (is_start) begin
      in_frame     <= 1'b1;
      parity       <= ~parity;
      keep[~parity] <= 1'b0;
      hi_match     <= 1'b0;
      byte_cnt     <= CNT_W'(1);
    end else if (is_end || is_body) begin
      if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
      if (is_end) in_frame <= 1'b0;
      if (byte_cnt == CNT_W'(ETYPE_HI_IDX))
        hi_match <= (iv_data[7:0] == TSMP_ETYPE[15:8]);
      if (byte_cnt == CNT_W'(ETYPE_LO_IDX))
        keep[parity] <= hi_match && (iv_data[7:0] == TSMP_ETYPE[7:0]);
    end else if (truncated) begin
      // Bytes of the broken frame still in flight must not leak out.
      in_frame     <= 1'b0;
      keep[parity] <= 1'b0;
    end
  end

  pip_delay_line #(
    .DEPTH(PIP_LATENCY),
    .WIDTH(STAGE_W)
  ) u_delay (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    (s_in),
    .q    (s_out)
  );

  assign fwd_ok = s_out.valid && keep[s_out.par];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data_wr <= 1'b0;
      ov_data   <= '0;
    end else begin
      o_data_wr <= fwd_ok;
      ov_data   <= fwd_ok ? s_out.data : '0;
    end
  end

endmodule

// File: tb/tb_pip.sv
// Directed self-checking bench for the TSMP frame filter.
module tb_pip;
  import pip_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] din;
  logic       din_wr;
  logic [8:0] dout;
  logic       dout_wr;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0] exp_d [4096];
  logic       exp_v [4096];

  always #5 clk = ~clk;

  pip #(.DATA_WIDTH(9)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .iv_data  (din),
    .i_data_wr(din_wr),
    .ov_data  (dout),
    .o_data_wr(dout_wr)
  );

  task automatic checkOutput(input int e);
    n_cmp++;
    assert (dout_wr === exp_v[e]) else begin
      n_fail++;
      $error("[TB] FAIL wr@%0d: observed %b expected %b", e, dout_wr, exp_v[e]);
    end
    n_cmp++;
    assert (dout === exp_d[e]) else begin
      n_fail++;
      $error("[TB] FAIL data@%0d: observed %h expected %h", e, dout, exp_d[e]);
    end
  endtask

  // One clock: drive inputs, record the expected output 14 edges later.
  task automatic applyStimulus(input logic [8:0] d, input logic wr, input logic fwd);
    int e;
    e = cyc;
    din    = d;
    din_wr = wr;
    if (!rst_n) begin
      for (int k = 0; k < PIP_LATENCY; k++) begin
        exp_v[e+k] = 1'b0;
        exp_d[e+k] = 9'h000;
      end
    end else if (fwd) begin
      exp_v[e+PIP_LATENCY] = 1'b1;
      exp_d[e+PIP_LATENCY] = d;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkOutput(e);
  endtask

  function automatic logic [8:0] frameByte(input int i, input logic [7:0] hi, input logic [7:0] lo);
    if (i == 0)       return 9'h101;
    else if (i == 1)  return 9'h001;
    else if (i < 12)  return 9'h000;
    else if (i == 12) return {1'b0, hi};
    else if (i == 13) return {1'b0, lo};
    else if (i < 16)  return 9'h000;
    else if (i < 82)  return 9'(i - 16);
    else              return 9'h100;
  endfunction

  // Full frames are 83 bytes; n_send < 83 leaves the frame unterminated.
  task automatic sendFrame(input logic [7:0] hi, input logic [7:0] lo,
                           input int n_send, input int n_fwd);
    for (int i = 0; i < n_send; i++)
      applyStimulus(frameByte(i, hi, lo), 1'b1, (i < n_fwd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(9'h000, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      exp_d[i] = 9'h000;
      exp_v[i] = 1'b0;
    end
    rst_n  = 1'b0;
    din    = 9'h000;
    din_wr = 1'b0;
    @(negedge clk);

    $display("[TB] reset");
    idle(3);
    rst_n = 1'b1;
    idle(2);

    $display("[TB] stray bytes outside a frame");
    applyStimulus(9'h055, 1'b1, 1'b0);
    applyStimulus(9'h0FF, 1'b1, 1'b0);
    idle(2);

    $display("[TB] TSMP frame");
    sendFrame(8'hFF, 8'h01, 83, 83);
    idle(16);

    $display("[TB] non-TSMP frame");
    sendFrame(8'hF1, 8'h00, 83, 0);
    idle(16);

    $display("[TB] back-to-back TSMP then non-TSMP");
    sendFrame(8'hFF, 8'h01, 83, 83);
    idle(1);
    sendFrame(8'hF1, 8'h00, 83, 0);
    idle(16);

    $display("[TB] short frame");
    applyStimulus(9'h101, 1'b1, 1'b0);
    for (int i = 1; i < 9; i++) applyStimulus(9'(i), 1'b1, 1'b0);
    applyStimulus(9'h100, 1'b1, 1'b0);
    idle(16);

    $display("[TB] mid-frame reset");
    sendFrame(8'hFF, 8'h01, 40, 40);
    rst_n = 1'b0;
    applyStimulus(9'h018, 1'b1, 1'b0);
    rst_n = 1'b1;
    idle(2);
    sendFrame(8'hFF, 8'h01, 83, 83);
    idle(16);

    // Bytes already past the output before the drop (0..6) are unavoidable.
    $display("[TB] truncated frame");
    sendFrame(8'hFF, 8'h01, 20, 7);
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
